// File: rtl/dco_freq_counter.sv
// dco_freq_counter: counts rising edges of the synchronized, divided DCO clock
// over a programmable window of sync_clock cycles. Each result is returned
// through a valid/ready handshake.
module dco_freq_counter #(
  parameter int unsigned CountWidth  = 16,
  parameter int unsigned WindowWidth = 16
) (
  input  logic                   sync_clock,
  input  logic                   reset,
  input  logic                   sync_dco,
  input  logic                   start,
  input  logic [WindowWidth-1:0] window_cycles,
  output logic [CountWidth-1:0]  count_out,
  output logic                   count_valid,
  input  logic                   count_ready,
  output logic                   busy,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic                   dco_q;
  logic                   rise;
  logic [CountWidth-1:0]  cnt_q, cnt_d, cnt_next;
  logic                   cnt_sat;
  logic [WindowWidth-1:0] remaining_q, remaining_d;
  logic [CountWidth-1:0]  count_out_q, count_out_d;
  logic                   count_valid_q, count_valid_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;

  assign rise = sync_dco & ~dco_q;

  // Next-state and next-output computation for the measurement FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    remaining_d   = remaining_q;
    count_out_d   = count_out_q;
    count_valid_d = count_valid_q;
    busy_d        = busy_q;
    overflow_d    = overflow_q;

    // A rise on an already full counter holds the count and flags overflow.
    cnt_sat  = rise && (cnt_q == '1);
    cnt_next = (rise && !cnt_sat) ? cnt_q + CountWidth'(1) : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (window_cycles == '0) begin
            count_out_d   = '0;
            count_valid_d = 1'b1;
            state_d       = HOLD;
          end else begin
            remaining_d = window_cycles;
            cnt_d       = '0;
            busy_d      = 1'b1;
            state_d     = MEASURE;
          end
        end
      end
      MEASURE: begin
        cnt_d       = cnt_next;
        remaining_d = remaining_q - WindowWidth'(1);
        if (cnt_sat) begin
          overflow_d = 1'b1;
        end
        if (remaining_q == WindowWidth'(1)) begin
          count_out_d   = cnt_next;
          count_valid_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (count_ready) begin
          count_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, registered outputs and the DCO edge-detect history.
  always_ff @(posedge sync_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dco_q         <= 1'b0;
      cnt_q         <= '0;
      remaining_q   <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dco_q         <= sync_dco;
      cnt_q         <= cnt_d;
      remaining_q   <= remaining_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_dco_freq_counter.sv
// Testbench for dco_freq_counter: a default-width instance and a 4-bit
// counter instance share stimulus; results are checked against a table and
// against an edge-counting reference model built from the recorded samples.
module tb_dco_freq_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sync_dco;
  logic        start;
  logic [15:0] window_cycles;
  logic        count_ready;

  logic [15:0] co16;
  logic        v16, b16, o16;
  logic [3:0]  co4;
  logic        v4, b4, o4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dco_freq_counter dut16 (
    .sync_clock   (clk),
    .reset        (reset),
    .sync_dco     (sync_dco),
    .start        (start),
    .window_cycles(window_cycles),
    .count_out    (co16),
    .count_valid  (v16),
    .count_ready  (count_ready),
    .busy         (b16),
    .overflow     (o16)
  );

  dco_freq_counter #(.CountWidth(4), .WindowWidth(16)) dut4 (
    .sync_clock   (clk),
    .reset        (reset),
    .sync_dco     (sync_dco),
    .start        (start),
    .window_cycles(window_cycles),
    .count_out    (co4),
    .count_valid  (v4),
    .count_ready  (count_ready),
    .busy         (b4),
    .overflow     (o4)
  );

  typedef struct {
    int w;
    int mode;
    int rdy;
    bit pre;
    int e16;
    int e4;
    int eo4;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DCO patterns indexed by cycle k relative to acceptance (k=0 is t0).
  function automatic bit gen(input int mode, input int k);
    case (mode)
      0:       gen = 1'($urandom_range(0, 1));
      1:       gen = (k % 2) == 1;
      2:       gen = 1'b1;
      default: gen = ((k / 3) % 2) == 1;
    endcase
  endfunction

  task automatic check_all(input string tag, input longint e16, input bit eo16,
                           input longint e4, input bit eo4, input bit ev, input bit eb);
    chk({tag, ".count16"}, co16, e16);
    chk({tag, ".ovf16"}, o16, eo16);
    chk({tag, ".count4"}, co4, e4);
    chk({tag, ".ovf4"}, o4, eo4);
    chk({tag, ".valid16"}, v16, ev);
    chk({tag, ".valid4"}, v4, ev);
    chk({tag, ".busy16"}, b16, eb);
    chk({tag, ".busy4"}, b4, eb);
  endtask

  task automatic run_meas(input string tag, input int w, input int mode, input int rdy,
                          input bit pre, input int t16, input int t4, input int to4);
    bit s[$];
    bit b;
    int n;
    longint m16, m4;
    bit mo4;
    b = gen(mode, 0);
    sync_dco = b;
    start = 1'b0;
    if (pre) tick();
    start = 1'b1;
    window_cycles = 16'(w);
    s.push_back(b);
    tick();  // acceptance edge t0
    start = 1'b0;
    for (int k = 1; k <= w; k++) begin
      chk({tag, ".busy_in_window"}, b16, 1);
      chk({tag, ".valid_in_window"}, v4, 0);
      b = gen(mode, k);
      sync_dco = b;
      s.push_back(b);
      start = 1'($urandom_range(0, 1));
      window_cycles = 16'($urandom);
      tick();
    end
    start = 1'b0;
    // Reference: count 0->1 transitions of the sampled DCO across t0..t0+W.
    n = 0;
    for (int k = 1; k <= w; k++) if (s[k] && !s[k-1]) n++;
    m16 = (n > 65535) ? 65535 : n;
    m4  = (n > 15) ? 15 : n;
    mo4 = n > 15;
    check_all({tag, ".result"}, m16, 1'b0, m4, mo4, 1'b1, 1'b0);
    if (t16 >= 0) begin
      chk({tag, ".table16"}, co16, t16);
      chk({tag, ".table4"}, co4, t4);
      chk({tag, ".table_ovf4"}, o4, to4);
    end
    for (int i = 0; i < rdy; i++) begin
      count_ready = 1'b0;
      start = 1'($urandom_range(0, 1));
      window_cycles = 16'($urandom);
      sync_dco = 1'($urandom_range(0, 1));
      tick();
      check_all({tag, ".backpressure"}, m16, 1'b0, m4, mo4, 1'b1, 1'b0);
    end
    count_ready = 1'b1;
    start = 1'b1;
    window_cycles = 16'd5;
    tick();  // handshake edge; start here must be ignored
    chk({tag, ".valid_drop16"}, v16, 0);
    chk({tag, ".valid_drop4"}, v4, 0);
    chk({tag, ".no_restart16"}, b16, 0);
    chk({tag, ".no_restart4"}, b4, 0);
    count_ready = 1'b0;
    start = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{100, 1, 0, 1'b1, 50, 15, 1});  // nominal, 4-bit saturates
    tbl.push_back('{20, 2, 0, 1'b1, 0, 0, 0});     // DCO held high: no spurious edge
    tbl.push_back('{40, 1, 0, 1'b1, 20, 15, 1});   // saturation
    tbl.push_back('{4, 1, 10, 1'b1, 2, 2, 0});     // overflow clears; backpressure
    tbl.push_back('{10, 1, 0, 1'b0, 5, 5, 0});     // start right after handshake
    tbl.push_back('{0, 0, 2, 1'b1, 0, 0, 0});      // zero window
    tbl.push_back('{1, 1, 0, 1'b1, 1, 1, 0});      // minimum window
    tbl.push_back('{30, 1, 0, 1'b1, 15, 15, 0});   // exactly full, no overflow
    tbl.push_back('{31, 1, 0, 1'b1, 16, 15, 1});   // one past full
    tbl.push_back('{24, 3, 1, 1'b1, 4, 4, 0});     // slow DCO, period 6
    for (int i = 0; i < 20; i++)
      tbl.push_back('{int'($urandom_range(0, 60)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b1, -1, -1, -1});

    reset = 1'b1;
    sync_dco = 1'b0;
    start = 1'b0;
    count_ready = 1'b0;
    window_cycles = '0;
    #12;
    check_all("reset", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Asynchronous reset mid-measurement with 7 edges counted so far.
    sync_dco = 1'b0;
    tick();
    start = 1'b1;
    window_cycles = 16'd30;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      sync_dco = (k % 2) == 1;
      tick();
    end
    chk("pre_reset.busy", b16, 1);
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    run_meas("after_reset", 10, 1, 0, 1'b1, 5, 5, 0);

    foreach (tbl[i])
      run_meas($sformatf("row%0d", i), tbl[i].w, tbl[i].mode, tbl[i].rdy, tbl[i].pre,
               tbl[i].e16, tbl[i].e4, tbl[i].eo4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
